// File: rtl/tick_time_counter.sv
// tick_time_counter: BCD 24h clock fed by divider ticks, with run/pause and manual field set
module tick_time_counter #(
  parameter int HR_MAX  = 24,
  parameter int MIN_MAX = 60,
  parameter int SEC_MAX = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       min_carry,
  output logic       day_wrap,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SET = 2'd2} state_t;
  localparam logic [7:0] SEC_TOP = 8'(((SEC_MAX - 1) / 10) * 16 + (SEC_MAX - 1) % 10);
  localparam logic [7:0] MIN_TOP = 8'(((MIN_MAX - 1) / 10) * 16 + (MIN_MAX - 1) % 10);
  localparam logic [7:0] HR_TOP  = 8'(((HR_MAX - 1) / 10) * 16 + (HR_MAX - 1) % 10);
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic wrap);
    return wrap ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  state_t     state_q, state_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic       carry_q, carry_d, day_q, day_d, tick_q, inc_q;
  logic       tick_rise, inc_rise, sec_wrap, min_wrap, hr_wrap;
  assign tick_rise = tick & ~tick_q;
  assign inc_rise  = inc & ~inc_q;
  assign sec_wrap  = sec_q == SEC_TOP;
  assign min_wrap  = min_q == MIN_TOP;
  assign hr_wrap   = hr_q == HR_TOP;
  always_comb begin
    state_d = set_mode ? SET : run ? RUN : IDLE;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    carry_d = 1'b0;
    day_d   = 1'b0;
    if (state_q == RUN && tick_rise) begin
      sec_d   = bcd_inc(sec_q, sec_wrap);
      min_d   = sec_wrap ? bcd_inc(min_q, min_wrap) : min_q;
      hr_d    = (sec_wrap && min_wrap) ? bcd_inc(hr_q, hr_wrap) : hr_q;
      carry_d = sec_wrap;
      day_d   = sec_wrap & min_wrap & hr_wrap;
    end else if (state_q == SET && inc_rise) begin
      // set mode advances one field only; wraps do not ripple
      sec_d = (set_sel == 2'd0) ? bcd_inc(sec_q, sec_wrap) : sec_q;
      min_d = (set_sel == 2'd1) ? bcd_inc(min_q, min_wrap) : min_q;
      hr_d  = (set_sel == 2'd2) ? bcd_inc(hr_q, hr_wrap) : hr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= 8'h00;
      carry_q <= 1'b0;
      day_q   <= 1'b0;
      tick_q  <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      carry_q <= carry_d;
      day_q   <= day_d;
      tick_q  <= tick;
      inc_q   <= inc;
    end
  end
  assign sec_bcd   = sec_q;
  assign min_bcd   = min_q;
  assign hr_bcd    = hr_q;
  assign min_carry = carry_q;
  assign day_wrap  = day_q;
  assign state     = state_q;
endmodule

// File: tb/tb_tick_time_counter.sv
// tb_tick_time_counter: vector table plus scripted sequences, expectations queued per driven cycle
module tb_tick_time_counter;
  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, run = 1'b0, set_mode = 1'b0, inc = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       min_carry, day_wrap;
  logic [1:0] state;
  typedef struct {
    logic [7:0] sec, min, hr;
    logic       mc, dw;
    logic [1:0] st;
  } exp_t;
  typedef struct {
    logic       r, tk, rn, sm;
    logic [1:0] sl;
    logic       ic;
    exp_t       e;
  } vec_t;
  exp_t sbq[$];
  int   errors = 0, checks = 0;
  tick_time_counter dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .set_mode(set_mode), .set_sel(set_sel),
    .inc(inc), .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
    .min_carry(min_carry), .day_wrap(day_wrap), .state(state)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction
  task automatic cyc(input string nm, input logic r, tk, rn, sm, input logic [1:0] sl,
                     input logic ic, input logic [7:0] es, em, eh, input logic ec, ed,
                     input logic [1:0] est);
    exp_t e;
    @(negedge clk);
    rst = r; tick = tk; run = rn; set_mode = sm; set_sel = sl; inc = ic;
    sbq.push_back('{es, em, eh, ec, ed, est});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    checks++;
    if ({sec_bcd, min_bcd, hr_bcd, min_carry, day_wrap, state} !==
        {e.sec, e.min, e.hr, e.mc, e.dw, e.st}) begin
      errors++;
      $display("FAIL %s: got %h:%h:%h mc=%b dw=%b st=%0d, expected %h:%h:%h mc=%b dw=%b st=%0d",
               nm, hr_bcd, min_bcd, sec_bcd, min_carry, day_wrap, state,
               e.hr, e.min, e.sec, e.mc, e.dw, e.st);
    end
  endtask
  task automatic set_field(input string nm, input logic [1:0] sl, input int n,
                           input int h0, m0, s0);
    for (int i = 1; i <= n; i++) begin
      int h = h0, m = m0, s = s0;
      if (sl == 2'd0) s = (s0 + i) % 60;
      if (sl == 2'd1) m = (m0 + i) % 60;
      if (sl == 2'd2) h = (h0 + i) % 24;
      cyc(nm, 0, 0, 0, 1, sl, 1, bcd(s), bcd(m), bcd(h), 0, 0, 2);
      cyc(nm, 0, 0, 0, 1, sl, 0, bcd(s), bcd(m), bcd(h), 0, 0, 2);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[14];
    tbl[0]  = '{0, 0, 1, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 1}};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 0}};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 1}};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, '{8'h37, 8'h00, 8'h00, 0, 0, 1}};
    tbl[10] = '{0, 1, 1, 0, 0, 0, '{8'h38, 8'h00, 8'h00, 0, 0, 1}};
    tbl[11] = '{0, 0, 1, 0, 0, 0, '{8'h38, 8'h00, 8'h00, 0, 0, 1}};
    tbl[12] = '{0, 1, 1, 0, 0, 1, '{8'h39, 8'h00, 8'h00, 0, 0, 1}};
    tbl[13] = '{0, 0, 1, 0, 0, 0, '{8'h39, 8'h00, 8'h00, 0, 0, 1}};
    // 1: sixty ticks roll seconds into minutes
    cyc("reset", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc("run_enter", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      cyc("tick60_hi", 0, 1, 1, 0, 0, 0, bcd(i % 60), bcd(i / 60), 8'h00, i == 60, 0, 1);
      cyc("tick60_lo", 0, 0, 1, 0, 0, 0, bcd(i % 60), bcd(i / 60), 8'h00, 0, 0, 1);
    end
    // 2: set 23:59:59 then one tick wraps the day
    cyc("reset2", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc("set_enter", 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2);
    set_field("set_hr", 2, 23, 0, 0, 0);
    set_field("set_min", 1, 59, 23, 0, 0);
    set_field("set_sec", 0, 59, 23, 59, 0);
    cyc("run_from_set", 0, 0, 1, 0, 0, 0, 8'h59, 8'h59, 8'h23, 0, 0, 1);
    cyc("day_wrap", 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1);
    cyc("day_wrap_end", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    // 3: a long tick pulse counts once
    cyc("long_tick_first", 0, 1, 1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      cyc("long_tick_hold", 0, 1, 1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1);
    cyc("long_tick_low", 0, 0, 1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1);
    // 4: set-mode minute wrap does not carry; sel 3 and ticks do nothing
    cyc("reset4", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc("set_enter4", 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2);
    set_field("set_min60", 1, 60, 0, 0, 0);
    set_field("set_none", 3, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("set_tick_hi", 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2);
      cyc("set_tick_lo", 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2);
    end
    // 5: pause at 37 s, resume latency, tick beats inc in RUN
    set_field("set_sec37", 0, 37, 0, 0, 0);
    foreach (tbl[k])
      cyc($sformatf("pause_vec%0d", k), tbl[k].r, tbl[k].tk, tbl[k].rn, tbl[k].sm, tbl[k].sl,
          tbl[k].ic, tbl[k].e.sec, tbl[k].e.min, tbl[k].e.hr, tbl[k].e.mc, tbl[k].e.dw,
          tbl[k].e.st);
    // 6: reset mid-run at 12:34:56
    cyc("reset6", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc("set_enter6", 0, 0, 0, 1, 2, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2);
    set_field("set6_hr", 2, 12, 0, 0, 0);
    set_field("set6_min", 1, 34, 12, 0, 0);
    set_field("set6_sec", 0, 56, 12, 34, 0);
    cyc("run6", 0, 0, 1, 0, 0, 0, 8'h56, 8'h34, 8'h12, 0, 0, 1);
    cyc("run6_tick", 0, 1, 1, 0, 0, 0, 8'h57, 8'h34, 8'h12, 0, 0, 1);
    cyc("mid_reset", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc("post_reset", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    cyc("post_reset_tick", 0, 1, 1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
